// File: rtl/lsu_ctrl.sv
// ============================================================================
// lsu_ctrl -- load/store unit controller
//
// Sits between the execute stage and a data memory with a combinational read
// port. Accepts one load or store at a time, drives the memory strobes from
// registers, and returns the extended load result together with the
// destination-register tag as a one-cycle response pulse.
//
// Compile-time option:
//   LSU_MISALIGNED_SPLIT_EN  defined   : misaligned loads become two aligned
//                                        word reads (SPLIT_LO/SPLIT_HI);
//                                        misaligned stores become a series of
//                                        byte stores (STBYTE).
//                            undefined : misaligned requests complete at once
//                                        with resp_misaligned=1.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE; the request fields need only be stable in
// the transfer cycle, because everything needed later is registered.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_load/req_store         operation select (exactly one must be high)
//   req_addr, req_wdata        byte address, right-justified store data
//   req_func3, req_tag         RV32 size/sign code, destination tag
//   memory_read/memory_write   memory strobes (never both high)
//   mem_addr/mem_wdata/mem_func3  memory address, write data, size code
//   mem_rdata                  combinational memory read data
//   resp_valid                 one-cycle completion pulse
//   resp_data/resp_tag         extended load result (0 otherwise), tag
//   resp_misaligned/illegal    fault flags
//   dbg_state                  current FSM state encoding
// ============================================================================
module lsu_ctrl #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_load,
    input  logic             req_store,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [2:0]       req_func3,
    input  logic [TAG_W-1:0] req_tag,
    output logic             memory_read,
    output logic             memory_write,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [2:0]       mem_func3,
    input  logic [31:0]      mem_rdata,
    output logic             resp_valid,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_misaligned,
    output logic             resp_illegal,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ACCESS   = 3'd1,
        S_SPLIT_LO = 3'd2,
        S_SPLIT_HI = 3'd3,
        S_STBYTE   = 3'd4,
        S_RESP     = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [2:0]         func3_q, func3_d;
    logic               is_load_q, is_load_d;

    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [2:0]         mem_func3_q, mem_func3_d;

    logic               resp_valid_q, resp_valid_d;
    logic [31:0]        resp_data_q, resp_data_d;
    logic [TAG_W-1:0]   resp_tag_q, resp_tag_d;
    logic               resp_mis_q, resp_mis_d;
    logic               resp_ill_q, resp_ill_d;

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        lo_q, lo_d;       // low word of a split load
    logic [2:0]         cnt_q, cnt_d;     // index of the next byte to store
    logic [2:0]         byte_last;        // number of bytes in a split store
    logic [31:0]        split_word;
`endif

    logic req_illegal;
    logic req_misaligned;

    // Sign/zero extension of right-justified load data by func3.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return f3[2] ? {24'b0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
            2'b01:   return f3[2] ? {16'b0, d[15:0]} : {{16{d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    always_comb begin
        req_illegal = 1'b0;
        if (req_load == req_store) begin
            req_illegal = 1'b1;
        end else if (req_load) begin
            req_illegal = (req_func3 == 3'b011) || (req_func3 == 3'b110) || (req_func3 == 3'b111);
        end else begin
            req_illegal = (req_func3 >= 3'b011);
        end
    end

    assign req_misaligned = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
                            ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

`ifdef LSU_MISALIGNED_SPLIT_EN
    assign byte_last  = (func3_q[1:0] == 2'b01) ? 3'd2 : 3'd4;
    // {hi,lo} shifted right by the byte offset brings the wanted bytes to bit 0.
    assign split_word = 32'({mem_rdata, lo_q} >> {addr_q[1:0], 3'b000});
`endif

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        func3_d      = func3_q;
        is_load_d    = is_load_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = 32'b0;
        mem_wdata_d  = 32'b0;
        mem_func3_d  = 3'b0;
        resp_valid_d = 1'b0;
        resp_data_d  = 32'b0;
        resp_tag_d   = '0;
        resp_mis_d   = 1'b0;
        resp_ill_d   = 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        lo_d         = lo_q;
        cnt_d        = cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    tag_d     = req_tag;
                    func3_d   = req_func3;
                    is_load_d = req_load;
                    if (req_illegal) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_ill_d   = 1'b1;
                        resp_tag_d   = req_tag;
                    end else if (req_misaligned) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        if (req_load) begin
                            state_d     = S_SPLIT_LO;
                            mem_read_d  = 1'b1;
                            mem_func3_d = 3'b010;
                            mem_addr_d  = {req_addr[31:2], 2'b00};
                        end else begin
                            state_d     = S_STBYTE;
                            mem_write_d = 1'b1;
                            mem_func3_d = 3'b000;
                            mem_addr_d  = req_addr;
                            mem_wdata_d = {24'b0, req_wdata[7:0]};
                            cnt_d       = 3'd1;
                        end
`else
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_mis_d   = 1'b1;
                        resp_tag_d   = req_tag;
`endif
                    end else begin
                        state_d     = S_ACCESS;
                        mem_read_d  = req_load;
                        mem_write_d = req_store;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = req_wdata;
                        mem_func3_d = req_func3;
                    end
                end
            end

            S_ACCESS: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_tag_d   = tag_q;
                resp_data_d  = is_load_q ? load_extend(func3_q, mem_rdata) : 32'b0;
            end

`ifdef LSU_MISALIGNED_SPLIT_EN
            S_SPLIT_LO: begin
                state_d     = S_SPLIT_HI;
                lo_d        = mem_rdata;
                mem_read_d  = 1'b1;
                mem_func3_d = 3'b010;
                mem_addr_d  = {addr_q[31:2], 2'b00} + 32'd4;
            end

            S_SPLIT_HI: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_tag_d   = tag_q;
                resp_data_d  = load_extend(func3_q, split_word);
            end

            S_STBYTE: begin
                if (cnt_q == byte_last) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_tag_d   = tag_q;
                end else begin
                    mem_write_d = 1'b1;
                    mem_func3_d = 3'b000;
                    mem_addr_d  = addr_q + {29'b0, cnt_q};
                    mem_wdata_d = {24'b0, wdata_q[8*cnt_q[1:0] +: 8]};
                    cnt_d       = cnt_q + 3'd1;
                end
            end
`endif

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tag_q        <= '0;
            func3_q      <= 3'b0;
            is_load_q    <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= 32'b0;
            mem_wdata_q  <= 32'b0;
            mem_func3_q  <= 3'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'b0;
            resp_tag_q   <= '0;
            resp_mis_q   <= 1'b0;
            resp_ill_q   <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            addr_q       <= 32'b0;
            wdata_q      <= 32'b0;
            lo_q         <= 32'b0;
            cnt_q        <= 3'b0;
`endif
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            func3_q      <= func3_d;
            is_load_q    <= is_load_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_func3_q  <= mem_func3_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_tag_q   <= resp_tag_d;
            resp_mis_q   <= resp_mis_d;
            resp_ill_q   <= resp_ill_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            lo_q         <= lo_d;
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign req_ready       = (state_q == S_IDLE);
    assign memory_read     = mem_read_q;
    assign memory_write    = mem_write_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_func3       = mem_func3_q;
    assign resp_valid      = resp_valid_q;
    assign resp_data       = resp_data_q;
    assign resp_tag        = resp_tag_q;
    assign resp_misaligned = resp_mis_q;
    assign resp_illegal    = resp_ill_q;
    assign dbg_state       = state_q;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit controller sitting between the core's execute stage and the data memory. It accepts one load or store request at a time and drives the memory's `memory_read`/`memory_write`/`addr`/`write_data`/`func3` port. Load data is returned sign- or zero-extended with its destination register tag. Misaligned accesses are either split into several aligned memory operations or reported as a fault, selected at compile time.

## Interface

Parameters:
- `TAG_W`, default 5: width of the destination-register tag.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; a request is accepted when `req_valid && req_ready`.
- `req_load` in 1: load request.
- `req_store` in 1: store request.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `req_func3` in 3: RV32 size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_tag` in `TAG_W`: destination register.
- `memory_read` out 1: memory read strobe.
- `memory_write` out 1: memory write strobe.
- `mem_addr` out 32: memory byte address.
- `mem_wdata` out 32: memory write data.
- `mem_func3` out 3: memory size code.
- `mem_rdata` in 32: combinational read data from memory.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_data` out 32: extended load result; 0 for stores and faults.
- `resp_tag` out `TAG_W`: tag of the completing request.
- `resp_misaligned` out 1: misaligned-access fault.
- `resp_illegal` out 1: illegal-request fault.

## Operation

- Request fields are registered on acceptance. Memory outputs are driven from registers only.
- Illegal request:
  - Condition: `req_load` and `req_store` both high, both low, a load with func3 011/110/111, or a store with func3 ≥ 011.
  - Response: goes directly to RESP with `resp_illegal`=1. No memory strobe.
- Misaligned access:
  - Definition: H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0.
  - Handling: depends on the macro; see Configuration.
- States and transitions:
  - IDLE: accept request, then go to ACCESS, SPLIT_LO, STBYTE, or RESP.
  - ACCESS: one aligned access with `mem_func3`=func3 and `mem_addr`=addr. For a load, `mem_rdata` is captured as `resp_data`. Go to RESP.
  - SPLIT_LO: `memory_read`, `mem_func3`=010, address `A & ~3`. Capture the low word. Go to SPLIT_HI.
  - SPLIT_HI: `memory_read`, func3 010, address `(A & ~3) + 4`, mod 2^32 so 0xFFFFFFFC wraps to 0. Result is `{hi,lo} >> (8*A[1:0])`, truncated to size and extended per func3. Go to RESP.
  - STBYTE: one byte store per cycle (func3 000). Address runs A, A+1, …, mod 2^32. Data is byte k of `req_wdata`. Count is 2 for H and 4 for W. After the last byte, go to RESP.
  - RESP: `resp_valid`=1 for one cycle, then go to IDLE.
- `memory_read` and `memory_write` are never both high.
- Reset:
  - All outputs are 0, state is IDLE, `req_ready`=1 after the reset cycle.
  - Reset during STBYTE abandons the store; bytes already written stay written. No response is produced.

## Timing

- Aligned load or store: accept at cycle 0, memory strobe at cycle 1, `resp_valid` at cycle 2.
- Split load: strobes at cycles 1 and 2, response at cycle 3.
- Split store: N strobes at cycles 1..N, response at cycle N+1.
- Fault: response at cycle 1, no strobe.
- `req_ready` is low from the cycle after acceptance through the RESP cycle. Back-to-back throughput is one aligned access per 3 cycles.
- Load data is sampled in the same cycle as `memory_read` (combinational memory read).
- The store write commits at the rising edge ending the strobe cycle.

## Configuration

- Macro: `LSU_MISALIGNED_SPLIT_EN`.
- Defined: misaligned loads use SPLIT_LO/SPLIT_HI; misaligned stores use STBYTE. No misaligned fault is ever raised.
- Undefined: the split states are not built. A misaligned request responds at cycle 1 with `resp_misaligned`=1, `resp_data`=0, and no memory strobe.

## Test plan

Memory preload for the scenarios below: word 0x100=0x44332211, word 0x104=0x88776655.

- Aligned LW at 0x100, tag 7: `memory_read` at cycle 1 with func3 010 → `resp_data`=0x44332211, tag 7, at cycle 2.
- Aligned LB at 0x107 → 0xFFFFFF88. Aligned LBU at 0x107 → 0x00000088. Aligned LHU at 0x106 → 0x00008877.
- With the macro defined:
  - LW at 0x102 → reads 0x100 then 0x104; `resp_data`=0x66554433 at cycle 3.
  - LH at 0x103 → 0x00005544.
- With the macro defined, SW 0xDEADBEEF at 0x101 → four byte stores to 0x101..0x104. Afterwards word 0x100=0xADBEEF11 and word 0x104=0x887766DE; response at cycle 5.
- With the macro undefined, LW at 0x102 → `resp_misaligned`=1 at cycle 1, no strobe. `req_load`=`req_store`=1 → `resp_illegal`=1.
- Assert `rst` during the second byte of a split SW → IDLE next cycle, no `resp_valid`, only the first byte modified, and a new LW is accepted immediately after.
